button_press_classifier: RTL and testbench

Multi-channel successor to the single-switch debouncer. For each of N_CH raw button inputs it synchronises, debounces, and classifies each press as short or long, with optional auto-repeat while a long press is held. It sits between the board push-buttons and the menu/control FSMs, which consume only its one-cycle ticks and debounced levels.

---
 rtl/button_pkg.sv | 26 ++
 rtl/press_channel.sv | 176 +++++++++++++++++
 rtl/button_press_classifier.sv | 50 +++++
 tb/tb_button_press_classifier.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared state encoding and width helper for the button
//               press classifier and its per-channel engine.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] DB_PRESS   = 3'd1;
    localparam logic [STATE_W-1:0] HELD       = 3'd2;
    localparam logic [STATE_W-1:0] HELD_LONG  = 3'd3;
    localparam logic [STATE_W-1:0] DB_RELEASE = 3'd4;

    // Counter width for a terminal count of x: max(1, $clog2(x)).
    function automatic int width_of(input int x);
        int w;
        w = $clog2(x);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/press_channel.sv
`default_nettype none
// ============================================================================
// Module      : press_channel
// Description : One button channel: 2-flop synchroniser, debounce FSM and
//               short / long / auto-repeat classification. All outputs are
//               registered one-cycle ticks plus the debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module press_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES     = 500_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DB_W   = width_of(DB_CYCLES);
    localparam int HOLD_W = width_of(LONG_CYCLES);
    localparam int REP_W  = width_of(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam int                REP_LAST_I = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_LAST_I);
    localparam bit                REP_EN    = (REPEAT_CYCLES > 0);

    logic [1:0]         sync_q;
    logic               sync;

    logic [STATE_W-1:0] state_q, state_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               long_flag_q, long_flag_d;

    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               repeat_q, repeat_d;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign sync = sync_q[1];

    // State, counter and registered-output storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            short_q     <= short_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    // Next-state and counter update; counters hold unless their state names them.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        long_flag_d = long_flag_q;

        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = DB_LOAD;
                end
            end

            DB_PRESS: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (db_cnt_q == '0) begin
                    state_d     = HELD;
                    hold_cnt_d  = '0;
                    long_flag_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q - 1'b1;
                end
            end

            HELD: begin
                // The cycle that first sees release still counts as held time,
                // so a bounce delays long_tick by exactly the DB_RELEASE cycles.
                if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (!sync) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = DB_LOAD;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = HELD_LONG;
                    long_flag_d = 1'b1;
                    rep_cnt_d   = '0;
                end
            end

            HELD_LONG: begin
                if (REP_EN) begin
                    rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + 1'b1;
                end
                if (!sync) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = DB_LOAD;
                end
            end

            DB_RELEASE: begin
                if (sync) begin
                    // Bounce: resume the hold phase without resetting counters.
                    state_d = long_flag_q ? HELD_LONG : HELD;
                end else if (db_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tick and level decode from the state transition about to be taken.
    always_comb begin
        level_d  = (state_d == HELD) || (state_d == HELD_LONG) || (state_d == DB_RELEASE);
        press_d  = (state_q == DB_PRESS)   && (state_d == HELD);
        long_d   = (state_q == HELD)       && (state_d == HELD_LONG);
        short_d  = (state_q == DB_RELEASE) && (state_d == IDLE) && !long_flag_q;
        repeat_d = REP_EN && (state_q == HELD_LONG) && (rep_cnt_q == REP_LAST);
    end

    assign level_o  = level_q;
    assign press_o  = press_q;
    assign short_o  = short_q;
    assign long_o   = long_q;
    assign repeat_o = repeat_q;

endmodule
`default_nettype wire

// File: rtl/button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : button_press_classifier
// Description : N_CH independent debounced push-button channels producing
//               press / short / long / repeat ticks and debounced levels.
// Revision    : 1.0 - initial release
// ============================================================================
module button_press_classifier
    import button_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int DB_CYCLES      = 500_000,
    parameter int LONG_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 12_500_000,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_tick,
    output logic [N_CH-1:0] short_tick,
    output logic [N_CH-1:0] long_tick,
    output logic [N_CH-1:0] repeat_tick
);

    logic [N_CH-1:0] btn_pressed;

    // Normalise polarity so every channel sees 1 = pressed.
    assign btn_pressed = btn_raw ^ {N_CH{BTN_ACTIVE_LOW}};

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        press_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_press_channel (
            .clk_i    (clk),
            .rst_ni   (reset_n),
            .btn_i    (btn_pressed[ch]),
            .level_o  (btn_level[ch]),
            .press_o  (press_tick[ch]),
            .short_o  (short_tick[ch]),
            .long_o   (long_tick[ch]),
            .repeat_o (repeat_tick[ch])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_press_classifier
// Description : Directed, scoreboard-based bench for button_press_classifier
//               with N_CH=2, DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_press_classifier;

    localparam int N_CH = 2;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    // Event kinds held in the scoreboard.
    localparam int K_PRESS = 0;
    localparam int K_SHORT = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;
    localparam int K_UP    = 4;
    localparam int K_DOWN  = 5;

    // Clean edge to tick latency: 2 sync + DB debounce + 1 register.
    localparam int LAT = 2 + DB + 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] press_tick;
    logic [N_CH-1:0] short_tick;
    logic [N_CH-1:0] long_tick;
    logic [N_CH-1:0] repeat_tick;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    ev_t             sbq[$];
    int              cyc    = 0;
    int              checks = 0;
    int              errors = 0;
    logic [N_CH-1:0] exp_lvl;

    button_press_classifier #(
        .N_CH           (N_CH),
        .DB_CYCLES      (DB),
        .LONG_CYCLES    (LONG),
        .REPEAT_CYCLES  (REP),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .press_tick  (press_tick),
        .short_tick  (short_tick),
        .long_tick   (long_tick),
        .repeat_tick (repeat_tick)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    task automatic expect_ev(input int dly, input int kind, input int ch);
        ev_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.ch   = ch;
        sbq.push_back(e);
    endtask

    task automatic check_vec(input string tag, input logic [N_CH-1:0] obs,
                             input logic [N_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_vec({tag, "_level"},  btn_level,   '0);
        check_vec({tag, "_press"},  press_tick,  '0);
        check_vec({tag, "_short"},  short_tick,  '0);
        check_vec({tag, "_long"},   long_tick,   '0);
        check_vec({tag, "_repeat"}, repeat_tick, '0);
    endtask

    // Advance one clock, retire due scoreboard entries and compare every output.
    task automatic step();
        ev_t             keep[$];
        logic [N_CH-1:0] e_press;
        logic [N_CH-1:0] e_short;
        logic [N_CH-1:0] e_long;
        logic [N_CH-1:0] e_rep;
        @(posedge clk);
        #1;
        cyc++;
        e_press = '0;
        e_short = '0;
        e_long  = '0;
        e_rep   = '0;
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) begin
                case (sbq[i].kind)
                    K_PRESS: e_press[sbq[i].ch] = 1'b1;
                    K_SHORT: e_short[sbq[i].ch] = 1'b1;
                    K_LONG:  e_long[sbq[i].ch]  = 1'b1;
                    K_REP:   e_rep[sbq[i].ch]   = 1'b1;
                    K_UP:    exp_lvl[sbq[i].ch] = 1'b1;
                    default: exp_lvl[sbq[i].ch] = 1'b0;
                endcase
            end else begin
                keep.push_back(sbq[i]);
            end
        end
        sbq = keep;
        check_vec("btn_level",   btn_level,   exp_lvl);
        check_vec("press_tick",  press_tick,  e_press);
        check_vec("short_tick",  short_tick,  e_short);
        check_vec("long_tick",   long_tick,   e_long);
        check_vec("repeat_tick", repeat_tick, e_rep);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_raw = 2'b11;
        exp_lvl = '0;

        // Reset held with both inputs high: everything stays at zero.
        steps(3);

        // Release reset with inputs still high: both channels accept together.
        reset_n = 1'b1;
        expect_ev(LAT, K_PRESS, 0);
        expect_ev(LAT, K_UP,    0);
        expect_ev(LAT, K_PRESS, 1);
        expect_ev(LAT, K_UP,    1);
        steps(10);
        btn_raw = 2'b00;
        expect_ev(LAT, K_SHORT, 0);
        expect_ev(LAT, K_DOWN,  0);
        expect_ev(LAT, K_SHORT, 1);
        expect_ev(LAT, K_DOWN,  1);
        steps(12);

        // Short press on ch0: 10 cycles high.
        btn_raw[0] = 1'b1;
        expect_ev(LAT, K_PRESS, 0);
        expect_ev(LAT, K_UP,    0);
        steps(10);
        btn_raw[0] = 1'b0;
        expect_ev(LAT, K_SHORT, 0);
        expect_ev(LAT, K_DOWN,  0);
        steps(12);

        // Glitches shorter than the debounce window: no activity at all.
        btn_raw[0] = 1'b1;
        steps(3);
        btn_raw[0] = 1'b0;
        steps(5);
        btn_raw[0] = 1'b1;
        steps(2);
        btn_raw[0] = 1'b0;
        steps(12);

        // Long press with auto-repeat on ch1, held 50 cycles.
        btn_raw[1] = 1'b1;
        expect_ev(LAT,              K_PRESS, 1);
        expect_ev(LAT,              K_UP,    1);
        expect_ev(LAT + LONG,       K_LONG,  1);
        expect_ev(LAT + LONG + REP, K_REP,   1);
        expect_ev(LAT + LONG + 2*REP, K_REP, 1);
        expect_ev(LAT + LONG + 3*REP, K_REP, 1);
        steps(50);
        btn_raw[1] = 1'b0;
        expect_ev(LAT, K_DOWN, 1);
        steps(12);

        // Release bounce at hold_cnt=10: long_tick slips by the 2 bounce cycles.
        btn_raw[0] = 1'b1;
        expect_ev(LAT,                  K_PRESS, 0);
        expect_ev(LAT,                  K_UP,    0);
        expect_ev(LAT + LONG + 2,       K_LONG,  0);
        expect_ev(LAT + LONG + 2 + REP, K_REP,   0);
        steps(LAT + 10);
        btn_raw[0] = 1'b0;
        steps(2);
        btn_raw[0] = 1'b1;
        steps(21);
        btn_raw[0] = 1'b0;
        expect_ev(LAT, K_DOWN, 0);
        steps(12);

        // Asynchronous reset while ch0 is in HELD_LONG.
        btn_raw[0] = 1'b1;
        expect_ev(LAT,        K_PRESS, 0);
        expect_ev(LAT,        K_UP,    0);
        expect_ev(LAT + LONG, K_LONG,  0);
        steps(30);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sbq.delete();
        exp_lvl = '0;
        steps(3);
        reset_n = 1'b1;
        expect_ev(LAT, K_PRESS, 0);
        expect_ev(LAT, K_UP,    0);
        steps(10);
        btn_raw[0] = 1'b0;
        expect_ev(LAT, K_SHORT, 0);
        expect_ev(LAT, K_DOWN,  0);
        steps(12);

        // Every expected event must have been consumed.
        checks++;
        assert (sbq.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
